// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and a host port.
// The core has priority; the host gets a forced grant after MAX_WAIT denied cycles and can lock bursts.
module dmem_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_rd_en,
  input  logic          core_wr_en,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {
    CORE = 1'b0,
    HOST = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            host_rvalid_q, host_rvalid_d;
  logic [DW-1:0]   host_rdata_q, host_rdata_d;

  logic            core_act;
  logic            core_serve;
  logic            host_rd_gnt;

  assign core_act = core_rd_en | core_wr_en;

  // Grant decision; everything is held off while reset is asserted.
  always_comb begin
    host_gnt   = 1'b0;
    core_serve = 1'b0;
    if (!reset) begin
      if (state_q == HOST) begin
        if (host_req) host_gnt = 1'b1;
        else          core_serve = core_act;
      end else begin
        if (host_req && (!core_act || wait_cnt_q == CW'(MAX_WAIT))) host_gnt = 1'b1;
        else                                                          core_serve = core_act;
      end
    end
    core_stall = core_act && !core_serve && !reset;
  end

  always_comb begin
    if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_rd_en = ~host_we;
      mem_wr_en = host_we;
    end else begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_rd_en = core_rd_en & core_serve;
      mem_wr_en = core_wr_en & core_serve;
    end
  end

  assign core_rdata  = mem_rdata;
  assign host_rd_gnt = host_gnt & ~host_we;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CORE:    if (host_gnt && host_lock)  state_d = HOST;
      HOST:    if (!host_req || !host_lock) state_d = CORE;
      default: state_d = CORE;
    endcase

    wait_cnt_d = '0;
    if (host_req && !host_gnt)
      wait_cnt_d = (wait_cnt_q == CW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + CW'(1);

    host_rvalid_d = host_rd_gnt;
    host_rdata_d  = host_rd_gnt ? mem_rdata : host_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CORE;
      wait_cnt_q    <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port data memory.
module tb_dmem_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       core_rd_en, core_wr_en;
  logic [7:0] core_addr, core_wdata, core_rdata;
  logic       core_stall;
  logic       host_req, host_we, host_lock;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_rd_en, mem_wr_en;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];
  int tests = 0;
  int fails = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .core_rd_en(core_rd_en), .core_wr_en(core_wr_en), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    core_rd_en = 0; core_wr_en = 0; core_addr = 0; core_wdata = 0;
    host_req = 0; host_we = 0; host_lock = 0; host_addr = 0; host_wdata = 0;
  endtask

  task automatic core(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    core_rd_en = rd; core_wr_en = wr; core_addr = a; core_wdata = d;
  endtask

  task automatic host(input logic rq, input logic we, input logic lk,
                      input logic [7:0] a, input logic [7:0] d);
    host_req = rq; host_we = we; host_lock = lk; host_addr = a; host_wdata = d;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    idle();
    reset = 1;

    // Reset with both requesters active: no grant, no stall, no memory enables
    cyc(); core(0, 1, 8'h99, 8'hEE); host(1, 1, 0, 8'h98, 8'hDD); #1;
    chk("rst_gnt", 32'(host_gnt), 0);
    chk("rst_stall", 32'(core_stall), 0);
    chk("rst_wr", 32'(mem_wr_en), 0);
    chk("rst_rd", 32'(mem_rd_en), 0);
    cyc(); reset = 0; idle(); #1;
    chk("rst_rvalid", 32'(host_rvalid), 0);
    chk("rst_rdata", 32'(host_rdata), 0);
    chk("rst_wait", 32'(dut.wait_cnt_q), 0);
    chk("rst_state", 32'(dut.state_q), 0);
    chk("rst_nowrite", 32'(mem[8'h99]), 0);

    // Core alone: store then load
    cyc(); core(0, 1, 8'h10, 8'h5A); #1;
    chk("c_st_stall", 32'(core_stall), 0);
    chk("c_st_gnt", 32'(host_gnt), 0);
    chk("c_st_wr", 32'(mem_wr_en), 1);
    cyc(); core(1, 0, 8'h10, 8'h00); #1;
    chk("c_ld_stall", 32'(core_stall), 0);
    chk("c_ld_data", 32'(core_rdata), 32'h5A);

    // Host read while core idle
    cyc(); idle(); host(1, 0, 0, 8'h10, 8'h00); #1;
    chk("h_rd_gnt", 32'(host_gnt), 1);
    chk("h_rd_rden", 32'(mem_rd_en), 1);
    cyc(); idle(); #1;
    chk("h_rd_rvalid", 32'(host_rvalid), 1);
    chk("h_rd_rdata", 32'(host_rdata), 32'h5A);
    cyc(); #1;
    chk("h_rd_rvalid_pulse", 32'(host_rvalid), 0);
    chk("h_rd_hold", 32'(host_rdata), 32'h5A);

    // Starvation: denied 4 cycles, forced grant in cycle 5
    for (int i = 1; i <= 4; i++) begin
      cyc(); core(1, 0, 8'h10, 8'h00); host(1, 1, 0, 8'h20, 8'hC3); #1;
      chk("sv_gnt", 32'(host_gnt), 0);
      chk("sv_stall", 32'(core_stall), 0);
      chk("sv_wait", 32'(dut.wait_cnt_q), 32'(i - 1));
    end
    cyc(); #1;
    chk("sv_force_gnt", 32'(host_gnt), 1);
    chk("sv_force_stall", 32'(core_stall), 1);
    chk("sv_force_addr", 32'(mem_addr), 32'h20);
    chk("sv_wait_sat", 32'(dut.wait_cnt_q), 4);
    cyc(); host(0, 0, 0, 8'h00, 8'h00); core(1, 0, 8'h20, 8'h00); #1;
    chk("sv_wait_clr", 32'(dut.wait_cnt_q), 0);
    chk("sv_resume", 32'(core_stall), 0);
    chk("sv_data", 32'(core_rdata), 32'hC3);

    // Locked burst entered through a forced grant; core store held off for 4 beats
    for (int i = 1; i <= 4; i++) begin
      cyc(); core(1, 0, 8'h10, 8'h00); host(1, 1, 1, 8'h30, 8'h00); #1;
      chk("bu_deny", 32'(host_gnt), 0);
    end
    stall_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(); core(0, 1, 8'h50, 8'h77); host(1, 1, (k < 3), 8'(8'h30 + k), 8'(k)); #1;
      chk("bu_gnt", 32'(host_gnt), 1);
      chk("bu_state", 32'(dut.state_q), (k == 0) ? 0 : 1);
      if (core_stall) stall_cnt++;
    end
    chk("bu_stall_cnt", 32'(stall_cnt), 4);
    cyc(); host(0, 0, 0, 8'h00, 8'h00); #1;
    chk("bu_exit_state", 32'(dut.state_q), 0);
    chk("bu_core_done", 32'(core_stall), 0);
    chk("bu_core_wr", 32'(mem_wr_en), 1);
    for (int k = 0; k < 4; k++) begin
      cyc(); core(1, 0, 8'(8'h30 + k), 8'h00); #1;
      chk("bu_readback", 32'(core_rdata), 32'(k));
    end
    cyc(); core(1, 0, 8'h50, 8'h00); #1;
    chk("bu_core_data", 32'(core_rdata), 32'h77);

    // Same-address collision: forced host write, core store retries and wins
    for (int i = 1; i <= 4; i++) begin
      cyc(); core(1, 0, 8'h41, 8'h00); host(1, 1, 0, 8'h40, 8'h11); #1;
    end
    chk("co_deny", 32'(host_gnt), 0);
    cyc(); core(0, 1, 8'h40, 8'h22); #1;
    chk("co_gnt", 32'(host_gnt), 1);
    chk("co_stall", 32'(core_stall), 1);
    chk("co_wdata", 32'(mem_wdata), 32'h11);
    cyc(); host(0, 0, 0, 8'h00, 8'h00); #1;
    chk("co_host_landed", 32'(mem[8'h40]), 32'h11);
    chk("co_retry", 32'(core_stall), 0);
    cyc(); core(1, 0, 8'h40, 8'h00); #1;
    chk("co_final", 32'(core_rdata), 32'h22);

    // Reset during the second locked host read
    cyc(); idle(); host(1, 0, 1, 8'h30, 8'h00); #1;
    chk("rb_gnt1", 32'(host_gnt), 1);
    cyc(); reset = 1; host(1, 0, 1, 8'h31, 8'h00); #1;
    chk("rb_state_host", 32'(dut.state_q), 1);
    chk("rb_gnt_rst", 32'(host_gnt), 0);
    chk("rb_rden_rst", 32'(mem_rd_en), 0);
    chk("rb_rvalid1", 32'(host_rvalid), 1);
    chk("rb_rdata1", 32'(host_rdata), 0);
    cyc(); reset = 0; idle(); core(1, 0, 8'h32, 8'h00); #1;
    chk("rb_no_rvalid", 32'(host_rvalid), 0);
    chk("rb_state", 32'(dut.state_q), 0);
    chk("rb_core_stall", 32'(core_stall), 0);
    chk("rb_core_data", 32'(core_rdata), 32'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
